// File: rtl/fibonacci_checker_if.sv
// Number stream into the Fibonacci checker: two lanes per cycle, lane0 older than lane1.
interface fibonacci_checker_if #(
  parameter int WIDTH = 16
);
  logic             in_vld0;
  logic [WIDTH-1:0] in_num0;
  logic             in_vld1;
  logic [WIDTH-1:0] in_num1;

  modport master (output in_vld0, in_num0, in_vld1, in_num1);
  modport slave  (input  in_vld0, in_num0, in_vld1, in_num1);
endinterface

// File: rtl/fibonacci_checker.sv
// Receive-side Fibonacci checker: checks each number against the sum of the two before it,
// with saturating match/error counters and a lock indicator. All outputs are registered.
module fibonacci_checker #(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 16,
  parameter int LOCK_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,
  fibonacci_checker_if.slave  stream,
  output logic                err,
  output logic                proto_err,
  output logic                locked,
  output logic [WIDTH-1:0]    expected,
  output logic [CNT_W-1:0]    match_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TRACK} state_t;

  localparam logic [7:0] RUN_MAX = 8'(LOCK_RUN);

  state_t           state, state_mid, state_nxt;
  logic [WIDTH-1:0] a, b, a_nxt, b_nxt;
  logic [7:0]       run, run_nxt;

  logic             proto, acc0, acc1;
  logic [WIDTH-1:0] sum0, sum1, exp_nxt;
  logic             chk0, chk1, hit0, hit1, miss0, miss1;
  logic [1:0]       n_hit, n_miss;
  logic [CNT_W:0]   mc_sum, ec_sum;
  logic [CNT_W-1:0] mc_nxt, ec_nxt;

  function automatic state_t advance(input state_t s);
    case (s)
      EMPTY:   advance = ONE;
      default: advance = TRACK;
    endcase
  endfunction

  // State register, history and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      a         <= '0;
      b         <= '0;
      run       <= '0;
      err       <= 1'b0;
      proto_err <= 1'b0;
      locked    <= 1'b0;
      expected  <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      run       <= run_nxt;
      err       <= miss0 | miss1;
      proto_err <= proto;
      locked    <= (run_nxt == RUN_MAX);
      expected  <= exp_nxt;
      match_cnt <= mc_nxt;
      err_cnt   <= ec_nxt;
    end
  end

  // Next state: lane0 advances the FSM first, lane1 continues from that intermediate state
  always_comb begin
    proto     = stream.in_vld1 & ~stream.in_vld0;
    acc0      = stream.in_vld0;
    acc1      = stream.in_vld0 & stream.in_vld1;
    state_mid = acc0 ? advance(state) : state;
    state_nxt = acc1 ? advance(state_mid) : state_mid;
  end

  // Checks, history shift, run length and counters
  always_comb begin
    sum0  = a + b;
    sum1  = b + stream.in_num0;
    chk0  = acc0 && (state == TRACK);
    chk1  = acc1 && (state_mid == TRACK);
    hit0  = chk0 && (stream.in_num0 == sum0);
    miss0 = chk0 && (stream.in_num0 != sum0);
    hit1  = chk1 && (stream.in_num1 == sum1);
    miss1 = chk1 && (stream.in_num1 != sum1);

    a_nxt = a;
    b_nxt = b;
    if (acc1) begin
      a_nxt = stream.in_num0;
      b_nxt = stream.in_num1;
    end else if (acc0) begin
      a_nxt = b;
      b_nxt = stream.in_num0;
    end

    // Run length applied lane by lane so a lane0 miss followed by a lane1 hit leaves run=1
    run_nxt = run;
    if (miss0)
      run_nxt = '0;
    else if (hit0 && run_nxt < RUN_MAX)
      run_nxt = run_nxt + 8'd1;
    if (miss1)
      run_nxt = '0;
    else if (hit1 && run_nxt < RUN_MAX)
      run_nxt = run_nxt + 8'd1;
    if (proto)
      run_nxt = '0;

    n_hit  = {1'b0, hit0} + {1'b0, hit1};
    n_miss = {1'b0, miss0} + {1'b0, miss1};
    mc_sum = {1'b0, match_cnt} + (CNT_W+1)'(n_hit);
    ec_sum = {1'b0, err_cnt} + (CNT_W+1)'(n_miss);
    mc_nxt = mc_sum[CNT_W] ? '1 : mc_sum[CNT_W-1:0];
    ec_nxt = ec_sum[CNT_W] ? '1 : ec_sum[CNT_W-1:0];

    exp_nxt = (state_nxt == TRACK) ? (a_nxt + b_nxt) : '0;
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker: driver queues hand-computed expectations, monitor checks them.
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        err, proto_err, locked;
  logic [15:0] expected, match_cnt, err_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic        err;
    logic        perr;
    logic        lock;
    logic [15:0] exp;
    logic [15:0] mc;
    logic [15:0] ec;
  } exp_t;

  exp_t sb[$];

  fibonacci_checker_if #(.WIDTH(16)) bus ();

  fibonacci_checker #(
    .WIDTH(16),
    .CNT_W(16),
    .LOCK_RUN(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stream    (bus.slave),
    .err       (err),
    .proto_err (proto_err),
    .locked    (locked),
    .expected  (expected),
    .match_cnt (match_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every registered output set is checked one edge after its stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("err",       {15'd0, err},       {15'd0, e.err});
        cmp("proto_err", {15'd0, proto_err}, {15'd0, e.perr});
        cmp("locked",    {15'd0, locked},    {15'd0, e.lock});
        cmp("expected",  expected,           e.exp);
        cmp("match_cnt", match_cnt,          e.mc);
        cmp("err_cnt",   err_cnt,            e.ec);
      end
    end
  end

  task automatic step(input logic r, input logic v0, input logic [15:0] n0,
                      input logic v1, input logic [15:0] n1,
                      input logic ee, input logic ep, input logic el,
                      input logic [15:0] ex, input logic [15:0] mc, input logic [15:0] ec);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.in_vld0 = v0;
    bus.in_num0 = n0;
    bus.in_vld1 = v1;
    bus.in_num1 = n1;
    e.err  = ee;
    e.perr = ep;
    e.lock = el;
    e.exp  = ex;
    e.mc   = mc;
    e.ec   = ec;
    sb.push_back(e);
  endtask

  // Reset with a live number on lane0 to show reset overrides inputs
  task automatic do_reset();
    step(1'b0, 1'b1, 16'd99, 1'b0, 16'd0, 0, 0, 0, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic s1(input logic [15:0] n, input logic ee, input logic el,
                    input logic [15:0] ex, input logic [15:0] mc, input logic [15:0] ec);
    step(1'b1, 1'b1, n, 1'b0, 16'd0, ee, 0, el, ex, mc, ec);
  endtask

  task automatic d2(input logic [15:0] n0, input logic [15:0] n1, input logic ee, input logic el,
                    input logic [15:0] ex, input logic [15:0] mc, input logic [15:0] ec);
    step(1'b1, 1'b1, n0, 1'b1, n1, ee, 0, el, ex, mc, ec);
  endtask

  initial begin
    bus.in_vld0 = 1'b0;
    bus.in_num0 = '0;
    bus.in_vld1 = 1'b0;
    bus.in_num1 = '0;

    // Single lane 1,1,2,3,5,8: lock after the fourth match
    do_reset();
    s1(16'd1, 0, 0, 16'd0,  16'd0, 16'd0);
    s1(16'd1, 0, 0, 16'd2,  16'd0, 16'd0);
    s1(16'd2, 0, 0, 16'd3,  16'd1, 16'd0);
    s1(16'd3, 0, 0, 16'd5,  16'd2, 16'd0);
    s1(16'd5, 0, 0, 16'd8,  16'd3, 16'd0);
    s1(16'd8, 0, 1, 16'd13, 16'd4, 16'd0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 0, 0, 1, 16'd13, 16'd4, 16'd0);

    // Dual lane pairs, then a protocol error and resumption
    do_reset();
    d2(16'd1,  16'd1,  0, 0, 16'd2,  16'd0, 16'd0);
    d2(16'd2,  16'd3,  0, 0, 16'd5,  16'd2, 16'd0);
    d2(16'd5,  16'd8,  0, 1, 16'd13, 16'd4, 16'd0);
    d2(16'd13, 16'd21, 0, 1, 16'd34, 16'd6, 16'd0);
    step(1'b1, 1'b0, 16'd0, 1'b1, 16'd7, 0, 1, 0, 16'd34, 16'd6, 16'd0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 0, 0, 0, 16'd34, 16'd6, 16'd0);
    s1(16'd34, 0, 0, 16'd55, 16'd7, 16'd0);

    // Modulo wrap: 40000 + 30000 = 4464 mod 65536
    do_reset();
    s1(16'd40000, 0, 0, 16'd0,     16'd0, 16'd0);
    s1(16'd30000, 0, 0, 16'd4464,  16'd0, 16'd0);
    s1(16'd4464,  0, 0, 16'd34464, 16'd1, 16'd0);

    // Corrupt 6 instead of 5, then a dual beat with lane0 miss and lane1 hit
    do_reset();
    s1(16'd1, 0, 0, 16'd0,  16'd0, 16'd0);
    s1(16'd1, 0, 0, 16'd2,  16'd0, 16'd0);
    s1(16'd2, 0, 0, 16'd3,  16'd1, 16'd0);
    s1(16'd3, 0, 0, 16'd5,  16'd2, 16'd0);
    s1(16'd6, 1, 0, 16'd9,  16'd2, 16'd1);
    s1(16'd9, 0, 0, 16'd15, 16'd3, 16'd1);
    d2(16'd1, 16'd10, 1, 0, 16'd11, 16'd4, 16'd2);

    // Reset mid-stream re-seeds without flagging an error
    do_reset();
    s1(16'd1,  0, 0, 16'd0,  16'd0, 16'd0);
    s1(16'd1,  0, 0, 16'd2,  16'd0, 16'd0);
    s1(16'd2,  0, 0, 16'd3,  16'd1, 16'd0);
    do_reset();
    s1(16'd10, 0, 0, 16'd0,  16'd0, 16'd0);
    s1(16'd20, 0, 0, 16'd30, 16'd0, 16'd0);
    s1(16'd30, 0, 0, 16'd50, 16'd1, 16'd0);

    @(negedge clk);
    bus.in_vld0 = 1'b0;
    bus.in_vld1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units, expected completion");
    $fatal(1, "timeout");
  end

endmodule
